// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle fetch/execute control FSM for the 4-bit CPU.
// Walks FETCH -> LOAD_IR -> EXEC -> (MEM_WB) -> NEXT and decodes the
// datapath control bus from the current state and the instruction register.
module exec_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             step,
   input  logic             halt_req,
   input  logic             bp_en,
   input  logic [2:0]       bp_addr,
   input  logic [2:0]       pc,
   input  logic [11:0]      ir,
   output logic             pc_enable,
   output logic             ir_we,
   output logic [2:0]       RF_ad1,
   output logic [2:0]       RF_ad2,
   output logic [2:0]       RF_wa,
   output logic             RF_we,
   output logic [2:0]       ALU_operation,
   output logic [3:0]       M_add,
   output logic             M_we,
   output logic             M_re,
   output logic             Mux_select,
   output logic             busy,
   output logic             bp_hit,
   output logic [CNT_W-1:0] instr_count,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_LOAD_IR = 3'd2,
      S_EXEC    = 3'd3,
      S_MEM_WB  = 3'd4,
      S_NEXT    = 3'd5
   } state_t;

   localparam logic [2:0] OP_STORE = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;

   state_t           state_d, state_q;
   logic             bp_hit_d, bp_hit_q;
   logic [CNT_W-1:0] instr_count_d, instr_count_q;
   logic             pc_enable_d, pc_enable_q;
   logic             ir_we_d, ir_we_q;
   logic             busy_d, busy_q;

   logic [2:0] op_s, rd_s, ra_s, rb_s;
   logic [3:0] addr_s;
   logic [2:0] pc_next_s;
   logic       bp_match_s;
   logic       go_s;

   assign op_s   = ir[11:9];
   assign rd_s   = ir[8:6];
   assign ra_s   = ir[5:3];
   assign rb_s   = ir[2:0];
   assign addr_s = ir[3:0];

   // The breakpoint is checked against the PC value the increment in NEXT will produce.
   assign pc_next_s  = pc + 3'd1;
   assign bp_match_s = bp_en && (bp_addr == pc_next_s);
   assign go_s       = run && !halt_req;

   // Next-state, sticky breakpoint flag, retire counter and state-only strobes.
   always_comb begin
      state_d       = state_q;
      bp_hit_d      = bp_hit_q;
      instr_count_d = instr_count_q;
      case (state_q)
         S_IDLE: begin
            if ((step || run) && !halt_req) begin
               state_d  = S_FETCH;
               bp_hit_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH:   state_d = S_LOAD_IR;
         S_LOAD_IR: state_d = S_EXEC;
         S_EXEC: begin
            if (op_s == OP_LOAD) begin
               state_d = S_MEM_WB;
            end else begin
               state_d = S_NEXT;
            end
         end
         S_MEM_WB:  state_d = S_NEXT;
         S_NEXT: begin
            if (instr_count_q != {CNT_W{1'b1}}) begin
               instr_count_d = instr_count_q + CNT_W'(1);
            end else begin
               instr_count_d = instr_count_q;
            end
            if (go_s && !bp_match_s) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
               // Only a run that would otherwise have continued was stopped by the breakpoint.
               if (go_s) begin
                  bp_hit_d = 1'b1;
               end else begin
                  bp_hit_d = bp_hit_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      pc_enable_d = (state_d == S_NEXT);
      ir_we_d     = (state_d == S_LOAD_IR);
      busy_d      = (state_d != S_IDLE);
   end

   // FSM state and registered state-only outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         bp_hit_q      <= 1'b0;
         instr_count_q <= '0;
         pc_enable_q   <= 1'b0;
         ir_we_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         bp_hit_q      <= bp_hit_d;
         instr_count_q <= instr_count_d;
         pc_enable_q   <= pc_enable_d;
         ir_we_q       <= ir_we_d;
         busy_q        <= busy_d;
      end
   end

   // Moore decode of the ir-dependent control bus. ir is only valid from the
   // first EXEC cycle, so these fields decode from the registered state and live ir.
   always_comb begin
      RF_ad1        = 3'd0;
      RF_ad2        = 3'd0;
      RF_wa         = 3'd0;
      RF_we         = 1'b0;
      ALU_operation = 3'd0;
      M_add         = 4'd0;
      M_we          = 1'b0;
      M_re          = 1'b0;
      Mux_select    = 1'b0;
      case (state_q)
         S_EXEC: begin
            case (op_s)
               OP_STORE: begin
                  RF_ad1 = rd_s;
                  M_add  = addr_s;
                  M_we   = 1'b1;
               end
               OP_LOAD: begin
                  M_add = addr_s;
                  M_re  = 1'b1;
               end
               default: begin
                  RF_ad1        = ra_s;
                  RF_ad2        = rb_s;
                  RF_wa         = rd_s;
                  RF_we         = 1'b1;
                  ALU_operation = op_s;
               end
            endcase
         end
         S_MEM_WB: begin
            M_add      = addr_s;
            M_re       = 1'b1;
            Mux_select = 1'b1;
            RF_wa      = rd_s;
            RF_we      = 1'b1;
         end
         default: begin
            RF_ad1 = 3'd0;
         end
      endcase
   end

   assign pc_enable   = pc_enable_q;
   assign ir_we       = ir_we_q;
   assign busy        = busy_q;
   assign bp_hit      = bp_hit_q;
   assign instr_count = instr_count_q;
   assign state       = state_q;

endmodule
